// File: rtl/rw_mem_pkg.sv
// -----------------------------------------------------------------------------
// rw_mem_pkg
// Shared definitions for the windowed RW RAM family in the 8-bit CPU data map.
//   state_t       : sequencer state (ST_CLEAR while zeroing, ST_RUN afterwards)
//   DEF_ADDR_W    : default CPU address width
//   DEF_DATA_W    : default data word width
//   PARITY_MAX_W  : widest word parity_even() accepts; narrower words are
//                   zero-extended by the caller, which leaves the parity intact
//   parity_even() : even-parity bit of a word (1 when the word has an odd
//                   number of ones, so word plus parity bit is always even)
// -----------------------------------------------------------------------------
package rw_mem_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int PARITY_MAX_W = 64;

  function automatic logic parity_even(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rw_window_decode.sv
// -----------------------------------------------------------------------------
// rw_window_decode
// Combinational address window decoder shared by the RAM, ROM and IO window
// blocks. An address hits when BASE <= address < BASE+DEPTH; idx is the word
// offset inside the window.
//
// Parameters:
//   ADDR_W : CPU address width
//   BASE   : first address inside the window
//   DEPTH  : number of words in the window (BASE+DEPTH <= 2**ADDR_W)
//
// Ports:
//   address in  ADDR_W          CPU address
//   hit     out 1               address lies inside the window
//   idx     out $clog2(DEPTH)   address - BASE, truncated
// -----------------------------------------------------------------------------
module rw_window_decode #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 128,
  parameter int DEPTH  = 96
) (
  input  logic [ADDR_W-1:0]        address,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  // One extra bit keeps BASE+DEPTH = 2**ADDR_W representable.
  localparam logic [ADDR_W:0] BASE_X  = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] offset;

  // The subtraction borrows into the top bit whenever address < BASE, which
  // makes the offset at least 2**ADDR_W and therefore never below DEPTH. A
  // single unsigned compare thus covers both window bounds, and it stays
  // free of constant-compare warnings when BASE is 0.
  always_comb begin
    offset = {1'b0, address} - BASE_X;
    hit    = (offset < DEPTH_X);
    idx    = offset[$clog2(DEPTH)-1:0];
  end

endmodule

// File: rtl/rw_window_ram.sv
// -----------------------------------------------------------------------------
// rw_window_ram
// Single-port synchronous RAM answering only inside the address window
// [BASE, BASE+DEPTH). After reset a sequencer zeroes every word (busy=1 for
// DEPTH cycles), during which all requests are ignored. Afterwards reads
// return data one cycle later with a rd_valid pulse, writes commit at the
// edge, and any request outside the window sets a sticky fault flag.
//
// Build option:
//   RW_WINDOW_RAM_PARITY_EN - when defined, every word carries an extra
//   even-parity bit and reads report a mismatch on parity_err. When
//   undefined, parity_err is tied 0 but the port is kept.
//
// Ports:
//   clk        in  1       system clock, rising edge
//   reset_n    in  1       asynchronous active-low reset
//   req        in  1       access strobe, one access per cycle
//   write      in  1       1=write, 0=read, sampled with req
//   address    in  ADDR_W  CPU address
//   data_in    in  DATA_W  write data
//   data_out   out DATA_W  registered read data
//   rd_valid   out 1       one-cycle pulse: data_out holds a fresh read
//   hit        out 1       combinational: address inside the window
//   busy       out 1       clear sequencer running, accesses ignored
//   fault      out 1       sticky: req issued outside the window
//   fault_clr  in  1       synchronous clear of fault
//   parity_err out 1       read parity mismatch (parity build only)
// -----------------------------------------------------------------------------
module rw_window_ram
  import rw_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BASE   = 128,
  parameter int DEPTH  = 96,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              hit,
  output logic              busy,
  output logic              fault,
  input  logic              fault_clr,
  output logic              parity_err
);

`ifdef RW_WINDOW_RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [MEM_W-1:0] mem [DEPTH];

  state_t           state;
  logic [IDX_W-1:0] clrPtr;
  logic [IDX_W-1:0] idx;
  logic             winHit;
  logic             doWrite;
  logic             doRead;
  logic             outOfWindow;
  logic             wrEn;
  logic [IDX_W-1:0] wrIdx;
  logic [MEM_W-1:0] wrWord;
  logic [MEM_W-1:0] storeWord;
  logic [MEM_W-1:0] readWord;

  rw_window_decode #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .DEPTH  (DEPTH)
  ) uDecode (
    .address (address),
    .hit     (winHit),
    .idx     (idx)
  );

  assign hit  = winHit;
  assign busy = (state == ST_CLEAR);

  // Requests only count once the clear sequencer has finished.
  always_comb begin
    doWrite     = (state == ST_RUN) && req && winHit && write;
    doRead      = (state == ST_RUN) && req && winHit && !write;
    outOfWindow = (state == ST_RUN) && req && !winHit;
    readWord    = mem[idx];
  end

  // The single write port is shared: the sequencer owns it while clearing,
  // the CPU owns it afterwards.
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = clrPtr;
    wrWord = '0;
    if (state == ST_CLEAR) begin
      wrEn = 1'b1;
    end else if (doWrite) begin
      wrEn   = 1'b1;
      wrIdx  = idx;
      wrWord = storeWord;
    end
  end

  // Storage array, deliberately without reset: the sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrIdx] <= wrWord;
    end
  end

  // Sequencer and registered outputs. The clear walks every index once and
  // moves to ST_RUN on the edge that writes the last word; ST_RUN is left
  // only through reset. Fault set is ordered after clear so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      clrPtr   <= '0;
      data_out <= '0;
      rd_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      rd_valid <= doRead;
      if (doRead) begin
        data_out <= readWord[DATA_W-1:0];
      end
      if (fault_clr) begin
        fault <= 1'b0;
      end
      if (outOfWindow) begin
        fault <= 1'b1;
      end
      if (state == ST_CLEAR) begin
        clrPtr <= clrPtr + 1'b1;
        if (clrPtr == LAST_IDX) begin
          state <= ST_RUN;
        end
      end
    end
  end

`ifdef RW_WINDOW_RAM_PARITY_EN
  logic [PARITY_MAX_W-1:0] wrExt;
  logic [PARITY_MAX_W-1:0] rdExt;

  // Zero-extend both words to the package function width; extra zeros do
  // not change the parity.
  always_comb begin
    wrExt                = '0;
    wrExt[DATA_W-1:0]    = data_in;
    rdExt                = '0;
    rdExt[DATA_W-1:0]    = readWord[DATA_W-1:0];
    storeWord            = {parity_even(wrExt), data_in};
  end

  // Parity check is registered with data_out so it lines up with rd_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= doRead && (parity_even(rdExt) != readWord[DATA_W]);
    end
  end
`else
  assign storeWord  = data_in;
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rw_window_ram.sv
// -----------------------------------------------------------------------------
// tb_rw_window_ram
// Self-checking bench for rw_window_ram. The default-parameter instance is
// tracked by a behavioural model (address-indexed memory, countdown of clear
// cycles) compared on every falling edge; directed sequences add literal
// expectations. A second instance covers BASE=0, DEPTH=256, DATA_W=16.
// Optional build: RW_WINDOW_RAM_PARITY_EN enables the parity sequence.
// -----------------------------------------------------------------------------
module tb_rw_window_ram;

  localparam int BASE  = 128;
  localparam int DEPTH = 96;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic        hit;
  logic        busy;
  logic        fault;
  logic        fault_clr;
  logic        parity_err;

  logic        reset2_n;
  logic        req2;
  logic        write2;
  logic [7:0]  address2;
  logic [15:0] data_in2;
  logic [15:0] data_out2;
  logic        rd_valid2;
  logic        hit2;
  logic        busy2;
  logic        fault2;
  logic        fault_clr2;
  logic        parity_err2;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;
  int flipAddr = -1;

  rw_window_ram #(
    .ADDR_W (8),
    .DATA_W (8),
    .BASE   (BASE),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .write      (write),
    .address    (address),
    .data_in    (data_in),
    .data_out   (data_out),
    .rd_valid   (rd_valid),
    .hit        (hit),
    .busy       (busy),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .parity_err (parity_err)
  );

  rw_window_ram #(
    .ADDR_W (8),
    .DATA_W (16),
    .BASE   (0),
    .DEPTH  (256)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset2_n),
    .req        (req2),
    .write      (write2),
    .address    (address2),
    .data_in    (data_in2),
    .data_out   (data_out2),
    .rd_valid   (rd_valid2),
    .hit        (hit2),
    .busy       (busy2),
    .fault      (fault2),
    .fault_clr  (fault_clr2),
    .parity_err (parity_err2)
  );

  always #5 clk = ~clk;

  // Model state: memory indexed by CPU address, cycles of clearing left,
  // and the outputs the DUT must show after the latest edge.
  logic [7:0] mdlMem [256];
  int         busyLeft  = DEPTH;
  logic [7:0] expData   = 8'h00;
  logic       expValid  = 1'b0;
  logic       expFault  = 1'b0;
  logic       expParity = 1'b0;

  function automatic logic inWindow(input logic [7:0] a);
    return (int'(a) >= BASE) && (int'(a) < BASE + DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input logic fc);
    req       = r;
    write     = w;
    address   = a;
    data_in   = d;
    fault_clr = fc;
    tick();
    req       = 1'b0;
    write     = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic access2(input logic w, input logic [7:0] a, input logic [15:0] d);
    req2     = 1'b1;
    write2   = w;
    address2 = a;
    data_in2 = d;
    tick();
    req2     = 1'b0;
    write2   = 1'b0;
  endtask

  // Behavioural model of the main instance, advanced on every rising edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busyLeft  <= DEPTH;
      expData   <= 8'h00;
      expValid  <= 1'b0;
      expFault  <= 1'b0;
      expParity <= 1'b0;
      for (int i = 0; i < 256; i++) mdlMem[i] <= 8'h00;
    end else if (busyLeft > 0) begin
      busyLeft  <= busyLeft - 1;
      expValid  <= 1'b0;
      expParity <= 1'b0;
    end else begin
      expValid  <= 1'b0;
      expParity <= 1'b0;
      if (req && !inWindow(address)) begin
        expFault <= 1'b1;
      end else if (fault_clr) begin
        expFault <= 1'b0;
      end
      if (req && inWindow(address)) begin
        if (write) begin
          mdlMem[address] <= data_in;
        end else begin
          expData   <= mdlMem[address];
          expValid  <= 1'b1;
          expParity <= (int'(address) == flipAddr);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_busy",     32'(busy),       32'(busyLeft > 0));
      checkOutput("cyc_hit",      32'(hit),        32'(inWindow(address)));
      checkOutput("cyc_data_out", 32'(data_out),   32'(expData));
      checkOutput("cyc_rd_valid", 32'(rd_valid),   32'(expValid));
      checkOutput("cyc_fault",    32'(fault),      32'(expFault));
      checkOutput("cyc_parity",   32'(parity_err), 32'(expParity));
    end
  end

  // Global time limit so the run always ends.
  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Directed sequences with literal expectations.
  initial begin
    int n;
    int misses;
    reset_n    = 1'b0;
    req        = 1'b0;
    write      = 1'b0;
    address    = 8'h00;
    data_in    = 8'h00;
    fault_clr  = 1'b0;
    reset2_n   = 1'b0;
    req2       = 1'b0;
    write2     = 1'b0;
    address2   = 8'h00;
    data_in2   = 16'h0000;
    fault_clr2 = 1'b0;

    #2;
    checkEn = 1'b1;
    checkOutput("rst_busy",     32'(busy),     32'd1);
    checkOutput("rst_data_out", 32'(data_out), 32'h0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_fault",    32'(fault),    32'd0);

    // Release reset; mid-clear, write 0xFF @140 (already cleared index)
    // and read an out-of-window address, both of which must be ignored.
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      if (n == 60) begin
        req = 1'b1; write = 1'b1; address = 8'd140; data_in = 8'hFF;
      end else if (n == 62) begin
        write = 1'b0; address = 8'd5;
      end else if (n == 63) begin
        req = 1'b0;
      end
      tick();
      n++;
    end
    req = 1'b0;
    checkOutput("clear_cycles", 32'(n), 32'd96);
    checkOutput("busy_no_fault", 32'(fault), 32'd0);

    // First reads: data one cycle after req, single-cycle valid.
    applyStimulus(1'b1, 1'b0, 8'd128, 8'h00, 1'b0);
    checkOutput("rd128_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd128_data",  32'(data_out), 32'h00);
    tick();
    checkOutput("rd128_valid_drop", 32'(rd_valid), 32'd0);

    applyStimulus(1'b1, 1'b1, 8'd130, 8'hA5, 1'b0);
    checkOutput("wr130_no_valid", 32'(rd_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd130, 8'h00, 1'b0);
    checkOutput("rd130_data",  32'(data_out), 32'hA5);
    checkOutput("rd130_valid", 32'(rd_valid), 32'd1);
    tick();
    checkOutput("rd130_valid_drop", 32'(rd_valid), 32'd0);
    checkOutput("rd130_hold",       32'(data_out), 32'hA5);

    applyStimulus(1'b1, 1'b0, 8'd140, 8'h00, 1'b0);
    checkOutput("rd140_busy_write_ignored", 32'(data_out), 32'h00);
    applyStimulus(1'b1, 1'b0, 8'd223, 8'h00, 1'b0);
    checkOutput("rd223_zero", 32'(data_out), 32'h00);
    applyStimulus(1'b1, 1'b1, 8'd223, 8'h3C, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd223, 8'h00, 1'b0);
    checkOutput("rd223_data", 32'(data_out), 32'h3C);

    // Out-of-window accesses and the sticky fault flag.
    applyStimulus(1'b1, 1'b0, 8'd127, 8'h00, 1'b0);
    checkOutput("rd127_fault",    32'(fault),    32'd1);
    checkOutput("rd127_no_valid", 32'(rd_valid), 32'd0);
    checkOutput("rd127_hold",     32'(data_out), 32'h3C);
    applyStimulus(1'b1, 1'b1, 8'd224, 8'h11, 1'b0);
    checkOutput("wr224_fault", 32'(fault), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'd224, 8'h00, 1'b0);
    checkOutput("rd224_hold",     32'(data_out), 32'h3C);
    checkOutput("rd224_no_valid", 32'(rd_valid), 32'd0);
    tick();
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'd224, 8'h00, 1'b1);
    checkOutput("fault_clr", 32'(fault), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd0, 8'h00, 1'b1);
    checkOutput("fault_set_wins", 32'(fault), 32'd1);

    // Async reset mid-run while rd_valid, data_out and fault are nonzero.
    applyStimulus(1'b1, 1'b0, 8'd223, 8'h00, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_data_out", 32'(data_out), 32'h0);
    checkOutput("arst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("arst_fault",    32'(fault),    32'd0);
    checkOutput("arst_busy",     32'(busy),     32'd1);

    // Reset again at cycle 40 of the clear; busy restarts the full count.
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_clear_busy", 32'(busy),     32'd1);
    checkOutput("arst_clear_data", 32'(data_out), 32'h0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reclear_cycles", 32'(n), 32'd96);
    applyStimulus(1'b1, 1'b0, 8'd223, 8'h00, 1'b0);
    checkOutput("rd223_recleared", 32'(data_out), 32'h00);
    checkOutput("rd223_re_valid",  32'(rd_valid), 32'd1);

`ifdef RW_WINDOW_RAM_PARITY_EN
    // Parity: clean read, then corrupt the stored parity bit and re-read.
    applyStimulus(1'b1, 1'b1, 8'd150, 8'h07, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'd150, 8'h00, 1'b0);
    checkOutput("par_clean", 32'(parity_err), 32'd0);
    checkOutput("par_data",  32'(data_out),   32'h07);
    dut.mem[150-BASE][8] = ~dut.mem[150-BASE][8];
    flipAddr = 150;
    applyStimulus(1'b1, 1'b0, 8'd150, 8'h00, 1'b0);
    checkOutput("par_err",       32'(parity_err), 32'd1);
    checkOutput("par_err_valid", 32'(rd_valid),   32'd1);
    checkOutput("par_err_data",  32'(data_out),   32'h07);
`endif

    // Full-range instance: every address hits and nothing faults.
    @(negedge clk);
    #1;
    reset2_n = 1'b1;
    n = 0;
    while (busy2 && n < 400) begin
      tick();
      n++;
    end
    checkOutput("sweep_clear_cycles", 32'(n), 32'd256);
    misses = 0;
    for (int a = 0; a < 256; a++) begin
      address2 = 8'(a);
      #1;
      if (!hit2) misses++;
    end
    checkOutput("sweep_all_hit", 32'(misses), 32'd0);
    access2(1'b1, 8'd255, 16'hBEEF);
    access2(1'b1, 8'd0,   16'h1234);
    access2(1'b0, 8'd255, 16'h0000);
    checkOutput("sweep_rd255",       32'(data_out2), 32'hBEEF);
    checkOutput("sweep_rd255_valid", 32'(rd_valid2), 32'd1);
    access2(1'b0, 8'd0, 16'h0000);
    checkOutput("sweep_rd0",    32'(data_out2),   32'h1234);
    checkOutput("sweep_fault",  32'(fault2),      32'd0);
    checkOutput("sweep_parity", 32'(parity_err2), 32'd0);

    tick();
    checkEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rw_window_ram.md
Name: rw_window_ram

Overview:
- Parametrised successor of the 96x8 windowed RW RAM in the 8-bit CPU data-memory map.
- Single-port synchronous RAM that answers only inside a configurable address window [BASE, BASE+DEPTH).
- Adds what the fixed block lacks:
  - explicit request strobe
  - read-valid pulse
  - sticky out-of-window fault
  - self-clearing initialisation sequencer after reset

Parameters:
- ADDR_W, 8, CPU address width.
- DATA_W, 8, word width.
- BASE, 128, first address inside the window.
- DEPTH, 96, number of words; BASE+DEPTH <= 2**ADDR_W, DEPTH >= 2.
- IDX_W, $clog2(DEPTH), internal index width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  access strobe, one access per cycle.
- write  in  1  1=write, 0=read; sampled with req.
- address  in  ADDR_W  CPU address.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  read data, registered.
- rd_valid  out  1  one-cycle pulse: data_out holds a fresh read.
- hit  out  1  combinational: address is inside the window.
- busy  out  1  clear sequencer running; accesses ignored.
- fault  out  1  sticky: req issued with hit=0.
- fault_clr  in  1  synchronous clear of fault.
- parity_err  out  1  read parity mismatch; see Optional Feature.

Behaviour:
- Window decode: hit = (address >= BASE) && (address < BASE+DEPTH).
  - idx = address - BASE, truncated to IDX_W.
  - Comparison is unsigned at ADDR_W+1 bits so BASE+DEPTH = 2**ADDR_W does not overflow.
- Reset (reset_n=0, async) forces:
  - data_out=0, rd_valid=0, fault=0, parity_err=0
  - state=ST_CLEAR, clr_ptr=0, busy=1
  - RAM contents are not reset directly.
- ST_CLEAR:
  - Each cycle: mem[clr_ptr] <= 0, clr_ptr++.
  - On the cycle writing clr_ptr==DEPTH-1, go to ST_RUN.
  - busy=1 for exactly DEPTH cycles after reset release.
  - req is ignored entirely in this state: no write, no rd_valid, no fault.
- ST_RUN (busy=0):
  - req & hit & write: mem[idx] <= data_in at the edge; data_out unchanged; rd_valid=0 next cycle.
  - req & hit & !write: data_out <= mem[idx] at the edge; rd_valid=1 for the following cycle only.
  - req & !hit: fault <= 1; no RAM access; data_out unchanged; rd_valid=0.
  - req=0: no action; data_out holds its last value.
- Read latency is 1 cycle.
- Back-to-back write then read of the same idx returns the new data; the write commits at the earlier edge.
- fault_clr=1 clears fault next edge. A simultaneous new fault and fault_clr leaves fault=1 (set wins).
- Reset asserted mid-clear or mid-run restarts ST_CLEAR from clr_ptr=0.
- ST_RUN is terminal until reset. No other state transitions exist.

Optional Feature:
- Macro: RW_WINDOW_RAM_PARITY_EN.
- Defined:
  - Storage is DATA_W+1 bits; the extra bit is the even-parity bit of data_in, stored on write.
  - The clear sequencer writes all-zero words with parity bit 0.
  - On a read, parity_err is registered alongside data_out and asserts with rd_valid when the recomputed parity differs from the stored bit.
  - parity_err does not alter data_out.
- Undefined:
  - Storage is DATA_W bits; parity_err is tied 0.
  - The port remains present so the interface is identical in both builds.

Decomposition:
- Package rw_mem_pkg:
  - state enum (ST_CLEAR, ST_RUN)
  - default ADDR_W/DATA_W constants
  - function parity_even(data)
- Sub-module rw_window_decode (ADDR_W, BASE, DEPTH): produces hit and idx combinationally; reused by the ROM and IO window blocks.

Test Plan:
- Reset release, defaults: busy=1 for 96 cycles, then 0. A read at 128 then returns 0x00 with a rd_valid pulse 1 cycle after req. A read at 223 likewise returns 0x00.
- Write 0xA5 @130, then read @130 next cycle: data_out=0xA5, rd_valid high for exactly one cycle. Write 0x3C @223 and read it back: 0x3C.
- Read @127, then write 0x11 @224: fault=1 and stays 1. A read @224 returns old data_out with no rd_valid. fault_clr=1 gives fault=0. fault_clr coincident with a req @0: fault remains 1.
- req write 0xFF @140 while busy=1: after clear completes, a read @140 returns 0x00 (write ignored) and fault=0.
- Assert reset_n=0 at cycle 40 of the clear: outputs zero immediately, without waiting for clk. After release, busy lasts 96 more cycles.
- With RW_WINDOW_RAM_PARITY_EN:
  - Write 0x07 @150, read it: parity_err=0.
  - Bench flips the stored parity bit of @150 via hierarchical deposit and reads again: parity_err=1 with rd_valid, data_out=0x07.
- Parameter sweep BASE=0, DEPTH=256, ADDR_W=8, DATA_W=16: every address hits; fault never sets; 0xBEEF @255 reads back intact.
